// File: rtl/tap_frame_serializer.sv
// tap_frame_serializer
//   Loads a 16 x 8-bit signed sample frame in one cycle and streams the
//   samples out in index order on a valid/ready interface. Sample k of the
//   frame is tap xk.
//
//   Optional feature macro: TAP_FRAME_SERIALIZER_SHADOW_EN
//     Adds a one-frame shadow buffer so a new frame can be queued while the
//     current one is streaming; frames then follow back to back with no bubble.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous active-low reset
//   x_flat      frame to load, sample k = x_flat[8k+7:8k]
//   load        load request
//   load_ready  load accepted on posedge with load && load_ready
//   xout        sample on the stream (active_buffer[idx])
//   xout_valid  xout holds a valid sample
//   xout_ready  downstream accepts the beat
//   xout_first  beat carries sample 0
//   xout_last   beat carries sample 15
//   idx         index of the sample on xout
//   busy        a frame is being sent
//   overrun     sticky: load seen while load_ready was low
module tap_frame_serializer (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] x_flat,
  input  logic         load,
  output logic         load_ready,
  output logic [7:0]   xout,
  output logic         xout_valid,
  input  logic         xout_ready,
  output logic         xout_first,
  output logic         xout_last,
  output logic [3:0]   idx,
  output logic         busy,
  output logic         overrun
);

  localparam int NUM_LANES = 16;
  localparam int VEC_W     = 8;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                              state_q, state_d;
  logic [3:0]                          idx_q, idx_d;
  logic [NUM_LANES-1:0][VEC_W-1:0]     act_q, act_d;
  logic [NUM_LANES-1:0][VEC_W-1:0]     x_frame;
  logic [VEC_W-1:0]                    xout_q, xout_d;
  logic                                vld_q, vld_d;
  logic                                first_q, first_d;
  logic                                last_q, last_d;
  logic                                ovr_q, ovr_d;
  logic                                accept, beat, last_beat;
`ifdef TAP_FRAME_SERIALIZER_SHADOW_EN
  logic [NUM_LANES-1:0][VEC_W-1:0]     shd_q, shd_d;
  logic                                shd_full_q, shd_full_d;
`endif

  assign x_frame   = x_flat;
`ifdef TAP_FRAME_SERIALIZER_SHADOW_EN
  assign load_ready = !shd_full_q;
`else
  assign load_ready = (state_q == IDLE);
`endif
  assign accept    = load && load_ready;
  assign beat      = vld_q && xout_ready;
  assign last_beat = beat && (idx_q == 4'hF);

  assign xout       = xout_q;
  assign xout_valid = vld_q;
  assign xout_first = first_q;
  assign xout_last  = last_q;
  assign idx        = idx_q;
  assign busy       = (state_q == SEND);
  assign overrun    = ovr_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      act_q      <= '0;
      xout_q     <= '0;
      vld_q      <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef TAP_FRAME_SERIALIZER_SHADOW_EN
      shd_q      <= '0;
      shd_full_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      act_q      <= act_d;
      xout_q     <= xout_d;
      vld_q      <= vld_d;
      first_q    <= first_d;
      last_q     <= last_d;
      ovr_q      <= ovr_d;
`ifdef TAP_FRAME_SERIALIZER_SHADOW_EN
      shd_q      <= shd_d;
      shd_full_q <= shd_full_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    act_d   = act_q;
    ovr_d   = ovr_q | (load & ~load_ready);
`ifdef TAP_FRAME_SERIALIZER_SHADOW_EN
    shd_d      = shd_q;
    shd_full_d = shd_full_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          act_d   = x_frame;
          idx_d   = 4'h0;
          state_d = SEND;
        end
      end
      SEND: begin
        // idx wraps 15 -> 0 naturally, which is the start of any follow-on frame
        if (beat) idx_d = idx_q + 4'h1;
        if (last_beat) begin
`ifdef TAP_FRAME_SERIALIZER_SHADOW_EN
          if (shd_full_q) begin
            act_d      = shd_q;
            shd_full_d = 1'b0;
          end else if (accept) begin
            // load coincides with the last beat: bypass the shadow
            act_d = x_frame;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
`ifdef TAP_FRAME_SERIALIZER_SHADOW_EN
        if (accept && !last_beat) begin
          shd_d      = x_frame;
          shd_full_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: registered stream outputs follow the next state so that
  // xout always equals active_buffer[idx] and holds while stalled.
  always_comb begin
    xout_d  = act_d[idx_d];
    vld_d   = (state_d == SEND);
    first_d = vld_d && (idx_d == 4'h0);
    last_d  = vld_d && (idx_d == 4'hF);
  end

endmodule

// File: tb/tb_tap_frame_serializer.sv
// Bench for tap_frame_serializer. A driver issues directed and random
// stimulus and queues every sample an accepted frame must produce; a monitor
// on the falling edge compares each presented beat against the queue head.
module tb_tap_frame_serializer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic         xout_ready = 1'b0;
  logic [127:0] x_flat = '0;
  logic         load_ready, xout_valid, xout_first, xout_last, busy, overrun;
  logic [7:0]   xout;
  logic [3:0]   idx;

  tap_frame_serializer dut (
    .clk(clk), .rst(rst), .x_flat(x_flat), .load(load), .load_ready(load_ready),
    .xout(xout), .xout_valid(xout_valid), .xout_ready(xout_ready),
    .xout_first(xout_first), .xout_last(xout_last), .idx(idx),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [3:0] k;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    mdl_ovr = 0;
  bit    mon_en = 0;
  bit    after_rst = 0;

  // Model: a load is acceptable when nothing is outstanding, or (with the
  // shadow) when at most the current frame is still outstanding.
  function automatic bit mdl_ready();
`ifdef TAP_FRAME_SERIALIZER_SHADOW_EN
    return exp_q.size() <= 16;
`else
    return exp_q.size() == 0;
`endif
  endfunction

  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    end
  endfunction

  function automatic logic [127:0] lin(input int base);
    logic [127:0] f;
    for (int k = 0; k < 16; k++) f[8*k +: 8] = 8'(base + k);
    return f;
  endfunction

  // One clock of stimulus; model updates are applied after the edge.
  task automatic cyc(input logic ld, input logic [127:0] d, input logic rdy, input logic rs);
    bit acc, ovr;
    load = ld; x_flat = d; xout_ready = rdy; rst = rs;
    acc = rs && ld && mdl_ready();
    ovr = rs && ld && !mdl_ready();
    @(posedge clk); #1;
    after_rst = !rs;
    if (!rs) begin
      exp_q.delete();
      mdl_ovr = 0;
    end else begin
      if (ovr) mdl_ovr = 1;
      if (acc) for (int k = 0; k < 16; k++) exp_q.push_back('{d: d[8*k +: 8], k: 4'(k)});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 300) begin
      cyc(1'b0, '0, 1'b1, 1'b1);
      t++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    idle(2);
  endtask

  // Monitor
  always @(negedge clk) begin
    beat_t e;
    bit    ev;
    if (mon_en) begin
      ev = exp_q.size() > 0;
      chk("load_ready", 32'(load_ready), 32'(mdl_ready()));
      chk("xout_valid", 32'(xout_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(ev));
      chk("overrun", 32'(overrun), 32'(mdl_ovr));
      if (after_rst) begin
        chk("rst_xout", 32'(xout), 32'd0);
        chk("rst_idx", 32'(idx), 32'd0);
      end
      if (ev) begin
        e = exp_q[0];
        chk("xout", 32'(xout), 32'(e.d));
        chk("idx", 32'(idx), 32'(e.k));
        chk("first", 32'(xout_first), 32'(e.k == 4'd0));
        chk("last", 32'(xout_last), 32'(e.k == 4'd15));
        if (xout_ready && rst) void'(exp_q.pop_front());
      end else begin
        chk("first_idle", 32'(xout_first), 32'd0);
        chk("last_idle", 32'(xout_last), 32'd0);
      end
    end
  end

  initial begin
    logic [127:0] alt;
    int p;
    alt = {8{16'h807F}};

    // reset for two cycles
    cyc(1'b0, '0, 1'b0, 1'b0);
    mon_en = 1;
    cyc(1'b0, '0, 1'b0, 1'b0);
    idle(1);

    // single frame -8..7 at full rate
    cyc(1'b1, lin(-8), 1'b1, 1'b1);
    drain();

    // backpressure pattern 1,0,0,...
    cyc(1'b1, lin(8'h10), 1'b0, 1'b1);
    p = 0;
    while (exp_q.size() > 0 && p < 200) begin
      cyc(1'b0, '0, 1'((p % 3) == 0), 1'b1);
      p++;
    end
    drain();

    // load during a frame at idx 5, then a load in idle
    cyc(1'b1, lin(8'h40), 1'b1, 1'b1);
    idle(5);
    cyc(1'b1, lin(8'h60), 1'b1, 1'b1);
    drain();
    cyc(1'b1, lin(8'h20), 1'b1, 1'b1);
    drain();

    // reset mid-frame after the beat at idx 9
    cyc(1'b1, lin(8'h30), 1'b1, 1'b1);
    idle(10);
    cyc(1'b0, '0, 1'b1, 1'b0);
    idle(4);

    // back-to-back frames A then B loaded at idx 3
    cyc(1'b1, lin(8'h00), 1'b1, 1'b1);
    idle(3);
    cyc(1'b1, lin(8'h80), 1'b1, 1'b1);
    drain();

    // load on the same edge as the last beat
    cyc(1'b1, lin(8'h50), 1'b1, 1'b1);
    idle(15);
    cyc(1'b1, lin(8'hA0), 1'b1, 1'b1);
    drain();

    // extreme values
    cyc(1'b1, alt, 1'b1, 1'b1);
    drain();

    // random traffic
    repeat (1500) begin
      cyc(1'($urandom_range(0, 7) == 0), {$urandom, $urandom, $urandom, $urandom},
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 299) != 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tap_frame_serializer.md
# tap_frame_serializer

Parallel-to-serial frame streamer for the DA-based LMS adaptive filter datapath. It loads a frame of 16 signed 8-bit samples in one cycle and emits them in index order, one per handshake, on a valid/ready stream. It is the read side of the 16-sample input capture stage: it serializes tap/sample frames for replay, error-path feedback and debug streaming. Sample k of the frame corresponds to tap xk.

## Interface
Parameters: none. Frame size is fixed at 16 samples of 8 bits.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset; sampled on posedge clk.
- x_flat  input  128  frame to load; sample k = x_flat[8k+7:8k], signed two's complement.
- load  input  1  request to load x_flat.
- load_ready  output  1  load is accepted on a posedge with load && load_ready.
- xout  output  8  signed sample being presented.
- xout_valid  output  1  xout holds a valid sample.
- xout_ready  input  1  downstream accepts; a beat transfers on a posedge with xout_valid && xout_ready.
- xout_first  output  1  high with the beat for sample 0.
- xout_last  output  1  high with the beat for sample 15.
- idx  output  4  index of the sample on xout.
- busy  output  1  a frame is active, meaning the FSM is in SEND.
- overrun  output  1  sticky; set when load is asserted while load_ready is low.

## Operation
- FSM states: IDLE and SEND.
- IDLE → SEND on an accepted load. The frame is copied into the active buffer and idx is set to 0.
- In SEND, each transferred beat increments idx.
- The beat with idx==15 (last) returns the FSM to IDLE, unless a next frame is pending (see Configuration). In that case the FSM stays in SEND with idx set to 0.
- xout always equals active_buffer[idx]. All outputs are registered.
- xout_first = xout_valid && idx==0.
- xout_last = xout_valid && idx==15.
- While xout_valid && !xout_ready, xout, idx, xout_first and xout_last hold stable indefinitely.
- Samples pass through unmodified. There is no sign or width conversion.
- overrun is set on any cycle where load && !load_ready. Only reset clears it. The rejected frame is discarded.
- Without a pending frame, load_ready = (state==IDLE).

## Timing
- Reset (rst low at posedge) sets:
  - FSM to IDLE; xout=0, xout_valid=0, xout_first=0, xout_last=0, idx=0, busy=0, overrun=0.
  - Active and shadow buffers to zero; shadow marked empty.
  - load_ready=1 from the first cycle after reset is released.
- Reset mid-frame discards all frame data immediately. No further beats are emitted.
- Load latency: load accepted at edge N → xout_valid=1 with sample 0 after edge N.
- Throughput: one beat per cycle while xout_ready is held high. A 16-beat frame occupies 16 cycles.
- After the last beat at edge M with no pending frame:
  - xout_valid=0 and load_ready=1 after edge M.
  - The earliest next sample 0 appears after edge M+1.
- load asserted during SEND in the non-shadow build counts as an overrun, including on the cycle of the last beat.

## Configuration
- Macro: TAP_FRAME_SERIALIZER_SHADOW_EN.
- Defined: a 16×8 shadow buffer is added.
  - load_ready = !shadow_full.
  - A load during SEND fills the shadow.
  - On the last beat with the shadow full, the shadow moves to the active buffer. Sample 0 of the new frame is presented after the same edge, with no bubble, and the shadow becomes empty.
  - If a load and the last beat occur on the same edge with the shadow empty, x_flat goes directly to the active buffer and is presented with no bubble.
  - A load in IDLE goes directly to the active buffer.
- Undefined: there is no shadow, and load_ready = (state==IDLE). Behaviour is exactly as described in Operation and Timing.

## Test plan
- Reset and single frame: hold rst low for 2 cycles and check all outputs are zero and load_ready=1. Load x_flat with sample k = k−8, hold xout_ready=1. Expect 16 consecutive beats −8…7, xout_first on −8, xout_last on 7, then xout_valid=0 and load_ready=1.
- Backpressure: load frame 0x10..0x1F and toggle xout_ready 1,0,0,1,… Expect xout/idx stable during stalls, all 16 values in order with none lost or duplicated, and xout_last only on 0x1F.
- Overrun: in the non-shadow build, assert load at idx=5. Expect overrun=1 (sticky) and the current frame to finish unchanged. A later load in IDLE is accepted and overrun stays 1 until reset.
- Reset mid-frame: after the beat at idx=9, pull rst low. Expect xout_valid=0, idx=0, busy=0 the next cycle, and no further beats.
- Shadow back-to-back (SHADOW_EN): load frame A (0x00..0x0F), load frame B (0x80..0x8F) at idx=3, xout_ready=1. Expect 32 contiguous beats 0x00…0x0F, 0x80…0x8F with no valid gap, and load_ready=0 from B's acceptance until the first beat of B.
- Extreme values: a frame alternating 0x7F/0x80. Expect xout to be bit-exact with no sign-extension artifacts.
